// File: rtl/clk_ena_prescaler.sv
// -----------------------------------------------------------------------------
// clk_ena_prescaler
//
// Upstream stage of the 8-bit timer counter. A free-running binary prescaler
// (div_cnt) advances while en=1. One of its low bits is selected by cks as the
// "tap". A rising edge on that tap produces a single-cycle, registered clk_ena
// strobe that advances the counter. Everything runs in the clk domain; there
// are no derived clocks.
//
// Tap k produces one clk_ena pulse every 2**(k+1) enabled clk cycles.
//
// Optional build macro: CLK_ENA_SYNC_RESTART_EN
//   Undefined (default): div_cnt free-runs across cks changes, so the new tap
//     keeps the phase of the current div_cnt value.
//   Defined: a cks change with en=1 clears div_cnt and the tap history on that
//     edge, so the new tap starts on the same schedule as after reset.
//
// Parameters:
//   DIV_WIDTH - prescaler width (number of selectable taps available)
//   SEL_WIDTH - width of cks; 2**SEL_WIDTH must not exceed DIV_WIDTH
//
// Ports:
//   clk      in   system clock, all flops on the rising edge
//   rst      in   synchronous active-high reset
//   en       in   prescaler run enable; 0 freezes div_cnt and blocks clk_ena
//   cks      in   tap select
//   clk_ena  out  registered single-cycle strobe to the counter
//   div_cnt  out  current prescaler value (debug/observation)
// -----------------------------------------------------------------------------
module clk_ena_prescaler #(
    parameter int DIV_WIDTH = 4,
    parameter int SEL_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [SEL_WIDTH-1:0] cks,
    output logic                 clk_ena,
    output logic [DIV_WIDTH-1:0] div_cnt
);

    localparam logic [DIV_WIDTH-1:0] DIV_ZERO = {DIV_WIDTH{1'b0}};
    localparam logic [DIV_WIDTH-1:0] DIV_ONE  = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

    // Every cks value must address an existing prescaler bit.
    if ((2 ** SEL_WIDTH) > DIV_WIDTH) begin : g_bad_params
        $error("clk_ena_prescaler: 2**SEL_WIDTH must not exceed DIV_WIDTH");
    end

    logic [DIV_WIDTH-1:0] div_cnt_q;
    logic [DIV_WIDTH-1:0] div_cnt_d;
    logic                 tap_d1_q;
    logic                 tap_d1_d;
    logic [SEL_WIDTH-1:0] cks_d1_q;
    logic [SEL_WIDTH-1:0] cks_d1_d;
    logic                 clk_ena_q;
    logic                 clk_ena_d;
    logic                 tap_s;
    logic                 cks_chg_s;

    // Next-state logic: prescaler increment, tap history and strobe detection.
    always_comb begin
        tap_s     = div_cnt_q[cks];
        cks_chg_s = (cks != cks_d1_q);
        cks_d1_d  = cks;

        // Rising edge on the selected tap, masked on the cycle cks changes:
        // switching from a low old tap to a high new tap is not a real edge.
        // A wrap of div_cnt is a falling edge on every tap, so it never pulses.
        clk_ena_d = en & tap_s & ~tap_d1_q & ~cks_chg_s;

        // tap_d1 follows the tap even while frozen, so no stale edge is left
        // pending when en is raised again.
        tap_d1_d  = tap_s;

        if (en) begin
            div_cnt_d = div_cnt_q + DIV_ONE;
        end else begin
            div_cnt_d = div_cnt_q;
        end

`ifdef CLK_ENA_SYNC_RESTART_EN
        // Restart the prescaler on a tap change so the new tap's first pulse
        // lands 2**k+1 edges later, exactly as after reset.
        if (en && cks_chg_s) begin
            div_cnt_d = DIV_ZERO;
            tap_d1_d  = 1'b0;
        end else begin
            div_cnt_d = div_cnt_d;
            tap_d1_d  = tap_d1_d;
        end
`endif
    end

    // State registers; reset takes priority over en and cks changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= DIV_ZERO;
            tap_d1_q  <= 1'b0;
            cks_d1_q  <= {SEL_WIDTH{1'b0}};
            clk_ena_q <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            tap_d1_q  <= tap_d1_d;
            cks_d1_q  <= cks_d1_d;
            clk_ena_q <= clk_ena_d;
        end
    end

    assign clk_ena = clk_ena_q;
    assign div_cnt = div_cnt_q;

endmodule

// File: tb/tb_clk_ena_prescaler.sv
// -----------------------------------------------------------------------------
// Self-checking bench for clk_ena_prescaler. A behavioural reference model
// computes the expected prescaler value and strobe from plain arithmetic on an
// integer count; directed scenarios also check the fixed pulse schedules.
// -----------------------------------------------------------------------------
module tb_clk_ena_prescaler;

    localparam int DIV_W = 4;
    localparam int SEL_W = 2;
    localparam int MOD   = 1 << DIV_W;

    logic             clk;
    logic             rst;
    logic             en;
    logic [SEL_W-1:0] cks;
    logic             clk_ena;
    logic [DIV_W-1:0] div_cnt;

    int n_checks;
    int n_fail;

    // Reference model state: the prescaler as a plain integer, the tap value
    // seen at the previous edge, the select seen at the previous edge.
    int m_div;
    int m_prev_tap;
    int m_prev_cks;
    int m_ena;
    int last_ena;

    clk_ena_prescaler #(.DIV_WIDTH(DIV_W), .SEL_WIDTH(SEL_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .cks     (cks),
        .clk_ena (clk_ena),
        .div_cnt (div_cnt)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clk edge using the inputs present at that edge.
    task automatic model_edge(input logic r, input logic e, input int k);
        int cur_tap;
        int chg;
        if (r) begin
            m_div = 0; m_prev_tap = 0; m_prev_cks = 0; m_ena = 0;
        end else begin
            cur_tap = (m_div / (1 << k)) % 2;
            chg     = (k != m_prev_cks);
            m_ena   = (e && cur_tap == 1 && m_prev_tap == 0 && !chg) ? 1 : 0;
`ifdef CLK_ENA_SYNC_RESTART_EN
            if (e && chg) begin
                m_div = 0; m_prev_tap = 0;
            end else begin
                m_div = e ? (m_div + 1) % MOD : m_div;
                m_prev_tap = cur_tap;
            end
`else
            m_div = e ? (m_div + 1) % MOD : m_div;
            m_prev_tap = cur_tap;
`endif
            m_prev_cks = k;
        end
    endtask

    // One clock: drive inputs on the falling edge, let the rising edge act,
    // then compare DUT against the model 1 ns later.
    task automatic step(input logic r, input logic e, input int k);
        @(negedge clk);
        rst = r; en = e; cks = SEL_W'(k);
        @(posedge clk);
        model_edge(r, e, k);
        #1;
        check_eq("model_clk_ena", int'(clk_ena), m_ena);
        check_eq("model_div_cnt", int'(div_cnt), m_div);
        check_eq("no_double_pulse", int'(clk_ena) & last_ena, 0);
        last_ena = int'(clk_ena);
    endtask

    task automatic do_reset(input int k, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            step(1'b1, 1'b1, k);
            check_eq("reset_clk_ena", int'(clk_ena), 0);
            check_eq("reset_div_cnt", int'(div_cnt), 0);
        end
    endtask

    initial begin
        int first_edge;
        int pulses;
        int found;
        int k_rand;
        logic e_rand;
        logic r_rand;

        n_checks = 0; n_fail = 0;
        m_div = 0; m_prev_tap = 0; m_prev_cks = 0; m_ena = 0; last_ena = 0;
        rst = 1'b1; en = 1'b0; cks = '0;

        // Scenarios 1/2: post-reset schedule for every tap over 64 edges.
        for (int k = 0; k < 4; k++) begin
            do_reset(k, 5);
            first_edge = 0; pulses = 0;
            for (int n = 1; n <= 64; n++) begin
                step(1'b0, 1'b1, k);
                if (clk_ena) begin
                    pulses++;
                    if (first_edge == 0) first_edge = n;
                    check_eq("pulse_phase", (n - ((1 << k) + 1)) % (1 << (k + 1)), 0);
                end
            end
            check_eq("first_pulse_edge", first_edge, (1 << k) + 1);
            check_eq("pulse_count_64", pulses, 64 / (1 << (k + 1)));
        end

        // Scenario 3: freeze with en=0 and resume without catch-up pulses.
        do_reset(3, 5);
        for (int n = 0; n < 5; n++) step(1'b0, 1'b1, 3);
        check_eq("freeze_div_before", int'(div_cnt), 5);
        for (int n = 0; n < 7; n++) begin
            step(1'b0, 1'b0, 3);
            check_eq("freeze_clk_ena", int'(clk_ena), 0);
            check_eq("freeze_div_hold", int'(div_cnt), 5);
        end
        found = 0;
        for (int n = 1; n <= 20 && found == 0; n++) begin
            step(1'b0, 1'b1, 3);
            if (n == 3) check_eq("resume_div_reaches_8", int'(div_cnt), 8);
            if (clk_ena) found = n;
        end
        check_eq("resume_pulse_edge", found, 4);

        // Scenario 4: cks 0 -> 2 while div_cnt=4 (old tap 0, new tap 1).
        do_reset(0, 3);
        for (int n = 0; n < 4; n++) step(1'b0, 1'b1, 0);
        check_eq("switch_div_before", int'(div_cnt), 4);
        step(1'b0, 1'b1, 2);
        check_eq("switch_no_pulse", int'(clk_ena), 0);
`ifdef CLK_ENA_SYNC_RESTART_EN
        check_eq("switch_restart_div", int'(div_cnt), 0);
        found = 0;
        for (int n = 1; n <= 20 && found == 0; n++) begin
            step(1'b0, 1'b1, 2);
            if (clk_ena) found = n;
        end
        check_eq("switch_restart_pulse", found, 5);
`else
        check_eq("switch_div_after", int'(div_cnt), 5);
        found = 0;
        for (int n = 1; n <= 20 && found == 0; n++) begin
            step(1'b0, 1'b1, 2);
            if (clk_ena) found = n;
        end
        // Pulse follows the div_cnt 11->12 transition: 8 edges after switch.
        check_eq("switch_next_pulse", found, 8);
        check_eq("switch_pulse_div", int'(div_cnt), 13);
`endif

        // Scenario 5: reset one edge before an expected cks=1 pulse.
        do_reset(1, 3);
        for (int n = 1; n <= 6; n++) step(1'b0, 1'b1, 1);
        step(1'b1, 1'b1, 1);
        check_eq("midrst_pulse_dropped", int'(clk_ena), 0);
        check_eq("midrst_div", int'(div_cnt), 0);
        found = 0;
        for (int n = 1; n <= 10 && found == 0; n++) begin
            step(1'b0, 1'b1, 1);
            if (clk_ena) found = n;
        end
        check_eq("midrst_resume_edge", found, 3);

        // Scenario 6: cks=0 drives a counter loaded with 10; overflow after
        // the 246th pulse, i.e. on edge 492 after release, none earlier.
        do_reset(0, 2);
        pulses = 0; found = 0;
        for (int n = 1; n <= 500; n++) begin
            step(1'b0, 1'b1, 0);
            if (clk_ena) begin
                pulses++;
                if (pulses == 246 && found == 0) found = n;
            end
        end
        check_eq("ovf_pulse_edge", found, 492);

        // Randomised run against the model.
        do_reset(0, 2);
        k_rand = 0;
        for (int n = 0; n < 1500; n++) begin
            r_rand = ($urandom_range(63) == 0);
            e_rand = ($urandom_range(3) != 0);
            if ($urandom_range(7) == 0) k_rand = int'($urandom_range(3));
            step(r_rand, e_rand, k_rand);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
